// File: rtl/vga_draw_pkg.sv
// Shared VGA drawing constants and scheduler FSM state encoding.
package vga_draw_pkg;

    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COL_W    = 3;
    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant, favours the requester not served last.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       served,
    output logic [1:0] grant
);

    logic favour1;

    always_ff @(posedge clk) begin
        if (reset) begin
            favour1 <= 1'b0;
        end else if (advance) begin
            favour1 <= ~served;
        end
    end

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = favour1 ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/rect_plot_scheduler.sv
// Shares the VGA plot port between two rectangle-fill requesters, one pixel per clock.
// Optional `RECT_CLIP_EN suppresses plot for pixels outside SCREEN_W x SCREEN_H.
module rect_plot_scheduler #(
    parameter int unsigned X_W      = vga_draw_pkg::X_W,
    parameter int unsigned Y_W      = vga_draw_pkg::Y_W,
    parameter int unsigned COL_W    = vga_draw_pkg::COL_W,
    parameter int unsigned SCREEN_W = vga_draw_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H = vga_draw_pkg::SCREEN_H
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*X_W-1:0]   req_x,
    input  logic [2*Y_W-1:0]   req_y,
    input  logic [2*X_W-1:0]   req_w,
    input  logic [2*Y_W-1:0]   req_h,
    input  logic [2*COL_W-1:0] req_colour,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [COL_W-1:0]   colour,
    output logic               plot,
    output logic               busy,
    output logic [1:0]         done
);

    import vga_draw_pkg::*;

    state_t           state, state_nx;
    logic [X_W-1:0]   x0, w, cx;
    logic [Y_W-1:0]   y0, h, cy;
    logic [COL_W-1:0] col;
    logic             owner;
    logic [1:0]       grant;
    logic             gidx, accept, advance, last_col, last_row, on_screen;
    logic [X_W:0]     x_sum;
    logic [Y_W:0]     y_sum;

    assign advance = (state == DONE);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (advance),
        .served  (owner),
        .grant   (grant)
    );

    assign gidx     = grant[1];
    assign last_col = (cx == w - X_W'(1));
    assign last_row = (cy == h - Y_W'(1));
    assign x_sum    = {1'b0, x0} + {1'b0, cx};
    assign y_sum    = {1'b0, y0} + {1'b0, cy};

`ifdef RECT_CLIP_EN
    assign on_screen = (x_sum < (X_W+1)'(SCREEN_W)) && (y_sum < (Y_W+1)'(SCREEN_H));
`else
    assign on_screen = 1'b1;
`endif

    always_comb begin
        req_ready = '0;
        state_nx  = state;
        if (state == IDLE) begin
            req_ready = grant;
        end
        accept = |req_ready;
        case (state)
            IDLE: begin
                if (accept) begin
                    if ((req_w[gidx*X_W +: X_W] == '0) || (req_h[gidx*Y_W +: Y_W] == '0)) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = DRAW;
                    end
                end
            end
            DRAW:    if (last_col && last_row) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        x      = '0;
        y      = '0;
        colour = '0;
        plot   = 1'b0;
        done   = '0;
        busy   = (state != IDLE);
        if (state == DRAW) begin
            x      = x_sum[X_W-1:0];
            y      = y_sum[Y_W-1:0];
            colour = col;
            plot   = on_screen;
        end
        if (state == DONE) begin
            done = owner ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            x0    <= '0;
            y0    <= '0;
            w     <= '0;
            h     <= '0;
            col   <= '0;
            owner <= 1'b0;
            cx    <= '0;
            cy    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (accept) begin
                        x0    <= req_x[gidx*X_W +: X_W];
                        y0    <= req_y[gidx*Y_W +: Y_W];
                        w     <= req_w[gidx*X_W +: X_W];
                        h     <= req_h[gidx*Y_W +: Y_W];
                        col   <= req_colour[gidx*COL_W +: COL_W];
                        owner <= gidx;
                        cx    <= '0;
                        cy    <= '0;
                    end
                end
                DRAW: begin
                    if (last_col) begin
                        cx <= '0;
                        cy <= cy + Y_W'(1);
                    end else begin
                        cx <= cx + X_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_plot_scheduler.sv
// Scoreboard bench: driver predicts grants and pushes expected pixels/done pulses; monitor pops and compares.
module tb_rect_plot_scheduler;

    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_ready;
    logic [2*XW-1:0] req_x = '0;
    logic [2*YW-1:0] req_y = '0;
    logic [2*XW-1:0] req_w = '0;
    logic [2*YW-1:0] req_h = '0;
    logic [2*CW-1:0] req_colour = '0;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [CW-1:0]   colour;
    logic            plot, busy;
    logic [1:0]      done;

    rect_plot_scheduler dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h), .req_colour(req_colour),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int w; int h; int col; } cmd_t;
    typedef struct { int x; int y; int col; int cyc; } pix_t;
    typedef struct { int owner; int cyc; } dn_t;

    cmd_t cq[2][$];
    pix_t pq[$];
    dn_t  dq[$];
    int   cyc = 0;
    int   checks = 0, errors = 0;
    int   next_acc = 0, favour = 0;
    int   busy_from = 1, busy_to = 0;
    bit   hold_valid = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model of one accepted command: every pixel in row-major order with its cycle stamp.
    task automatic model_accept(input int gi, input int e);
        cmd_t c;
        int n, px, py;
        c = cq[gi].pop_front();
        n = c.w * c.h;
        for (int r = 0; r < c.h; r++) begin
            for (int k = 0; k < c.w; k++) begin
                px = c.x + k;
                py = c.y + r;
`ifdef RECT_CLIP_EN
                if (px < 160 && py < 120) pq.push_back('{px, py, c.col, e + r*c.w + k});
`else
                pq.push_back('{px % 256, py % 128, c.col, e + r*c.w + k});
`endif
            end
        end
        dq.push_back('{gi, e + n});
        busy_from = e;
        busy_to   = e + n;
        next_acc  = e + n + 2;
        favour    = 1 - gi;
    endtask

    task automatic drive_cycle();
        int e, g, gi;
        logic [1:0] v;
        cmd_t c;
        @(negedge clk);
        #2;
        e = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            v[i] = (cq[i].size() > 0) && (hold_valid || ($urandom_range(0, 3) != 0));
            if (v[i]) begin
                c = cq[i][0];
                req_x[i*XW +: XW]      = c.x[XW-1:0];
                req_y[i*YW +: YW]      = c.y[YW-1:0];
                req_w[i*XW +: XW]      = c.w[XW-1:0];
                req_h[i*YW +: YW]      = c.h[YW-1:0];
                req_colour[i*CW +: CW] = c.col[CW-1:0];
            end else begin
                req_x[i*XW +: XW]      = XW'($urandom);
                req_y[i*YW +: YW]      = YW'($urandom);
                req_w[i*XW +: XW]      = XW'($urandom);
                req_h[i*YW +: YW]      = YW'($urandom);
                req_colour[i*CW +: CW] = CW'($urandom);
            end
        end
        req_valid = v;
        #1;
        g = 0;
        if (e >= next_acc) g = (v == 2'b11) ? (favour == 1 ? 2 : 1) : int'(v);
        check("req_ready", int'(req_ready), g);
        if (g != 0) begin
            gi = (g == 2) ? 1 : 0;
            model_accept(gi, e);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (!(cq[0].size() == 0 && cq[1].size() == 0 && cyc + 1 >= next_acc
                 && pq.size() == 0 && dq.size() == 0)) begin
            if (n >= budget) begin
                check("drain_timeout", n, -1);
                return;
            end
            drive_cycle();
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        req_valid = '0;
        pq.delete();
        dq.delete();
        cq[0].delete();
        cq[1].delete();
        favour = 0;
        busy_from = 1;
        busy_to = 0;
        @(negedge clk);
        #1;
        check("reset_plot", int'(plot), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_ready", int'(req_ready), 0);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        next_acc = cyc + 1;
    endtask

    task automatic push_cmd(input int r, input int cx, input int cy, input int cw, input int ch, input int cc);
        cq[r].push_back('{cx, cy, cw, ch, cc});
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("busy", int'(busy), (cyc >= busy_from && cyc <= busy_to) ? 1 : 0);
            if (plot) begin
                if (pq.size() == 0) begin
                    check("unexpected_plot_x", int'(x), -1);
                end else begin
                    pix_t p;
                    p = pq.pop_front();
                    check("pixel_x", int'(x), p.x);
                    check("pixel_y", int'(y), p.y);
                    check("pixel_colour", int'(colour), p.col);
                    check("pixel_cycle", cyc, p.cyc);
                end
            end
            if (done != 2'b00) begin
                if (dq.size() == 0) begin
                    check("unexpected_done", int'(done), 0);
                end else begin
                    dn_t d;
                    d = dq.pop_front();
                    check("done_owner", int'(done), 1 << d.owner);
                    check("done_cycle", cyc, d.cyc);
                end
            end
        end
    end

    initial begin
        do_reset();

        push_cmd(0, 10, 5, 3, 2, 4);
        drain(100);

        push_cmd(0, 1, 2, 2, 2, 1);
        push_cmd(0, 20, 30, 1, 3, 2);
        push_cmd(1, 40, 50, 3, 1, 5);
        push_cmd(1, 60, 70, 2, 1, 6);
        drain(200);

        push_cmd(1, 7, 7, 0, 5, 3);
        drain(50);

        push_cmd(1, 0, 0, 160, 120, 0);
        push_cmd(0, 3, 3, 2, 2, 7);
        drain(19500);

        push_cmd(0, 158, 118, 4, 4, 5);
        drain(100);

        push_cmd(1, 0, 0, 160, 120, 0);
        repeat (300) drive_cycle();
        do_reset();
        push_cmd(0, 9, 9, 2, 3, 6);
        drain(100);

        hold_valid = 1'b0;
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < 8; k++) begin
                push_cmd($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 127),
                         $urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 7));
            end
            drain(2000);
        end

        repeat (3) @(negedge clk);
        check("pixels_left", pq.size(), 0);
        check("dones_left", dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
